// File: rtl/hazard_pkg.sv
// Shared constants for the microinstruction hazard controller: NOP encoding and field positions.
package hazard_pkg;

   localparam int unsigned NOP_W       = 33;
   localparam logic [NOP_W-1:0] NOP_MIR = 33'h008E3400;

   localparam int unsigned RD_W_BIT    = 5;
   localparam int unsigned WR_W_BIT    = 6;
   localparam int unsigned RD_REG_BIT  = 7;
   localparam int unsigned WR_REG_BIT  = 8;
   localparam int unsigned DST_LSB     = 12;
   localparam int unsigned SRC_B_LSB   = 18;
   localparam int unsigned SRC_A_LSB   = 26;

   localparam int unsigned FWD_SEL_W   = 3;
   localparam int unsigned CNT_W       = 16;

   // Forward-select code for tracker entry idx (0 is reserved for "no forward").
   function automatic logic [FWD_SEL_W-1:0] fwd_code(input int idx);
      return FWD_SEL_W'(idx + 1);
   endfunction

endpackage

// File: rtl/hazard_tracker.sv
// In-flight writer tracker: shift register of issued instructions and per-entry match vectors.
module hazard_tracker
   import hazard_pkg::*;
#(
   parameter int unsigned RADDR_W   = 6,
   parameter int unsigned STAGES    = 2,
   parameter int unsigned IGNORE_R0 = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               shift_en,
   input  logic               flush,
   input  logic               in_valid,
   input  logic               in_wr_reg,
   input  logic               in_wr_w,
   input  logic [RADDR_W-1:0] in_dst,
   input  logic [RADDR_W-1:0] src_a,
   input  logic [RADDR_W-1:0] src_b,
   output logic [STAGES-1:0]  match_a,
   output logic [STAGES-1:0]  match_b,
   output logic [STAGES-1:0]  match_w
);

   logic [STAGES-1:0]  valid;
   logic [STAGES-1:0]  wr_reg;
   logic [STAGES-1:0]  wr_w;
   logic [RADDR_W-1:0] dst [STAGES];

   // Entry 0 takes the issued instruction; older entries age by one slot per accepted cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid  <= '0;
         wr_reg <= '0;
         wr_w   <= '0;
         for (int i = 0; i < int'(STAGES); i++) begin
            dst[i] <= '0;
         end
      end else if (flush) begin
         valid <= '0;
      end else if (shift_en) begin
         for (int i = 1; i < int'(STAGES); i++) begin
            valid[i]  <= valid[i-1];
            wr_reg[i] <= wr_reg[i-1];
            wr_w[i]   <= wr_w[i-1];
            dst[i]    <= dst[i-1];
         end
         valid[0]  <= in_valid;
         wr_reg[0] <= in_wr_reg;
         wr_w[0]   <= in_wr_w;
         dst[0]    <= in_dst;
      end
   end

   // Per-entry address and W-register conflicts against the operand-stage sources.
   always_comb begin
      match_a = '0;
      match_b = '0;
      match_w = '0;
      for (int i = 0; i < int'(STAGES); i++) begin
         match_a[i] = valid[i] && wr_reg[i] && (dst[i] == src_a)
                      && !((IGNORE_R0 != 0) && (dst[i] == '0));
         match_b[i] = valid[i] && wr_reg[i] && (dst[i] == src_b)
                      && !((IGNORE_R0 != 0) && (dst[i] == '0));
         match_w[i] = valid[i] && wr_w[i];
      end
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Operand-stage hazard controller: stalls or forwards against in-flight writers, inserts NOP bubbles.
module pipe_hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int unsigned MIR_W     = 33,
   parameter int unsigned RADDR_W   = 6,
   parameter int unsigned STAGES    = 2,
   parameter int unsigned FWD_EN    = 0,
   parameter int unsigned IGNORE_R0 = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [MIR_W-1:0]     mir_op,
   input  logic                 op_valid,
   input  logic                 ex_ready,
   input  logic                 flush,
   output logic [MIR_W-1:0]     uc_mir,
   output logic                 uc_enable,
   output logic [FWD_SEL_W-1:0] fwd_sel_a,
   output logic [FWD_SEL_W-1:0] fwd_sel_b,
   output logic [CNT_W-1:0]     hazard_cnt
);

   logic [RADDR_W-1:0] src_a;
   logic [RADDR_W-1:0] src_b;
   logic [RADDR_W-1:0] dst;
   logic               rd_reg;
   logic               rd_w;
   logic [STAGES-1:0]  match_a;
   logic [STAGES-1:0]  match_b;
   logic [STAGES-1:0]  match_w;
   logic               reg_conflict;
   logic               w_conflict;
   logic               hazard;
   logic               issue;
   logic               bubble;

   assign src_a  = mir_op[SRC_A_LSB +: RADDR_W];
   assign src_b  = mir_op[SRC_B_LSB +: RADDR_W];
   assign dst    = mir_op[DST_LSB +: RADDR_W];
   assign rd_reg = op_valid && mir_op[RD_REG_BIT];
   assign rd_w   = op_valid && mir_op[RD_W_BIT];

   hazard_tracker #(
      .RADDR_W   (RADDR_W),
      .STAGES    (STAGES),
      .IGNORE_R0 (IGNORE_R0)
   ) u_tracker (
      .clk       (clk),
      .rst_n     (rst_n),
      .shift_en  (ex_ready),
      .flush     (flush),
      .in_valid  (issue),
      .in_wr_reg (mir_op[WR_REG_BIT]),
      .in_wr_w   (mir_op[WR_W_BIT]),
      .in_dst    (dst),
      .src_a     (src_a),
      .src_b     (src_b),
      .match_a   (match_a),
      .match_b   (match_b),
      .match_w   (match_w)
   );

   // Stall condition: forwarding mode can only bypass from entries older than the youngest.
   always_comb begin
      reg_conflict = 1'b0;
      w_conflict   = 1'b0;
      if (FWD_EN != 0) begin
         reg_conflict = match_a[0] || match_b[0];
         w_conflict   = match_w[0];
      end else begin
         reg_conflict = (|match_a) || (|match_b);
         w_conflict   = |match_w;
      end
      hazard = rst_n && ((rd_reg && reg_conflict) || (rd_w && w_conflict));
   end

   // Forward source select: scanning oldest to youngest lets the lowest-index match win.
   always_comb begin
      fwd_sel_a = '0;
      fwd_sel_b = '0;
      if ((FWD_EN != 0) && rst_n && rd_reg) begin
         for (int i = int'(STAGES) - 1; i >= 1; i--) begin
            if (match_a[i]) fwd_sel_a = fwd_code(i);
            if (match_b[i]) fwd_sel_b = fwd_code(i);
         end
      end
   end

   // Issue decision: flush beats a stalled execute stage, which beats a hazard.
   always_comb begin
      uc_mir    = MIR_W'(NOP_MIR);
      uc_enable = 1'b0;
      issue     = 1'b0;
      bubble    = 1'b0;
      if (flush) begin
         uc_enable = 1'b1;
      end else if (!ex_ready) begin
         uc_enable = 1'b0;
      end else if (!op_valid) begin
         uc_enable = 1'b1;
      end else if (hazard) begin
         bubble = 1'b1;
      end else begin
         uc_mir    = mir_op;
         uc_enable = 1'b1;
         issue     = 1'b1;
      end
   end

   // Saturating count of inserted bubbles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hazard_cnt <= '0;
      end else if (bubble && (hazard_cnt != '1)) begin
         hazard_cnt <= hazard_cnt + CNT_W'(1);
      end
   end

endmodule
